// File: rtl/mnist_input_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : mnist_input_streamer
//  Description : Streams one image frame of N_INPUTS pixels from a pixel
//                memory (one-cycle read latency) to the network input port
//                using a ready/ack handshake. FSM: IDLE/FETCH/WAIT/SEND/DONE.
//                Optional macro MNIST_STREAMER_FRAME_CNT_EN adds a 16-bit
//                completed-frame counter output frame_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module mnist_input_streamer #(
    parameter int N_INPUTS = 784,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              inp_rdy,
    input  logic              inp_ack,
    output logic [DATA_W-1:0] inp_data,
    output logic [ADDR_W-1:0] inp_count,
    output logic              busy,
    output logic              done
`ifdef MNIST_STREAMER_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_cnt
`endif
);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_FETCH = 3'd1;
    localparam logic [2:0] c_S_WAIT  = 3'd2;
    localparam logic [2:0] c_S_SEND  = 3'd3;
    localparam logic [2:0] c_S_DONE  = 3'd4;

    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(N_INPUTS - 1);
    localparam logic [ADDR_W-1:0] c_ONE      = ADDR_W'(1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_inp_count;
    logic [DATA_W-1:0] r_inp_data;
    logic              w_last;
    logic              w_accept;
    logic              w_launch;

    assign w_last   = (r_inp_count == c_LAST_IDX);
    // Abort beats everything except reset, so it masks both frame launch and pixel acceptance.
    assign w_accept = (r_state == c_S_SEND) && inp_ack && !abort;
    assign w_launch = (r_state == c_S_IDLE) && start && !abort;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort forces IDLE from any active state
    always_comb begin
        w_state_nxt = r_state;
        if (r_state != c_S_IDLE && abort) begin
            w_state_nxt = c_S_IDLE;
        end else begin
            case (r_state)
                c_S_IDLE:  w_state_nxt = w_launch ? c_S_FETCH : c_S_IDLE;
                c_S_FETCH: w_state_nxt = c_S_WAIT;
                c_S_WAIT:  w_state_nxt = c_S_SEND;
                c_S_SEND: begin
                    if (w_accept) begin
                        w_state_nxt = w_last ? c_S_DONE : c_S_FETCH;
                    end
                end
                c_S_DONE:  w_state_nxt = c_S_IDLE;
                default:   w_state_nxt = c_S_IDLE;
            endcase
        end
    end

    // Output decode from the current state
    always_comb begin
        mem_rd_en = (r_state == c_S_FETCH);
        inp_rdy   = (r_state == c_S_SEND);
        busy      = (r_state != c_S_IDLE);
        // An abort landing on the DONE cycle cancels the completion pulse.
        done      = (r_state == c_S_DONE) && !abort;
    end

    // Pixel index and captured pixel data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inp_count <= '0;
            r_inp_data  <= '0;
        end else begin
            if (w_launch) begin
                r_inp_count <= '0;
            end else if (w_accept && !w_last) begin
                r_inp_count <= r_inp_count + c_ONE;
            end
            if (r_state == c_S_WAIT) begin
                r_inp_data <= mem_rd_data;
            end
        end
    end

    assign mem_addr  = r_inp_count;
    assign inp_count = r_inp_count;
    assign inp_data  = r_inp_data;

`ifdef MNIST_STREAMER_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Completed-frame counter, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if (r_state == c_S_DONE && !abort) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mnist_input_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mnist_input_streamer
//  Description : Directed self-checking bench for mnist_input_streamer with
//                a one-cycle-latency pixel memory model (word[i] = i + 100).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mnist_input_streamer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [15:0] mem_rd_data;
    logic        inp_rdy;
    logic        inp_ack;
    logic [15:0] inp_data;
    logic [9:0]  inp_count;
    logic        busy;
    logic        done;
`ifdef MNIST_STREAMER_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int total;
    int bad;

    mnist_input_streamer #(
        .N_INPUTS (784),
        .DATA_W   (16),
        .ADDR_W   (10)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .inp_rdy     (inp_rdy),
        .inp_ack     (inp_ack),
        .inp_data    (inp_data),
        .inp_count   (inp_count),
        .busy        (busy),
        .done        (done)
`ifdef MNIST_STREAMER_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Pixel memory: word[i] = i + 100, data one cycle after the read strobe
    always_ff @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= 16'(mem_addr + 10'd100);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch a frame and advance with ack high until the FETCH of pixel px
    task automatic start_and_run_to(input int px);
        int n;
        inp_ack = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (n = 0; n < 3000; n++) begin
            if (mem_rd_en && mem_addr == 10'(px)) break;
            step();
        end
        if (n >= 3000) begin
            total++; bad++;
            $display("FAIL run_to_%0d: timeout, inp_count=%0d required fetch of %0d", px, inp_count, px);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; inp_ack = 1'b0;
        step(); step();
        total++;
        if ({inp_rdy, mem_rd_en, busy, done} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got rdy/rd/busy/done=%b required 0000", {inp_rdy, mem_rd_en, busy, done});
        end
        total++;
        if (inp_count !== 10'd0 || inp_data !== 16'd0) begin
            bad++;
            $display("FAIL reset_regs: got count=%0d data=%0d required 0/0", inp_count, inp_data);
        end
        reset = 1'b0;
        step();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_full_frame();
        int n_xfer, n_done, last_t, t, addr_bad;
        n_xfer = 0; n_done = 0; last_t = -1; addr_bad = 0;
        inp_ack = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (t = 0; t < 784 * 3 + 20; t++) begin
            if (t > 0 && !busy) break;
            if (mem_addr !== inp_count) addr_bad++;
            if (done === 1'b1) n_done++;
            if (inp_rdy && inp_ack) begin
                total++;
                if (inp_count !== 10'(n_xfer) || inp_data !== 16'(n_xfer + 100)) begin
                    bad++;
                    $display("FAIL xfer_%0d: got count=%0d data=%0d required %0d/%0d",
                             n_xfer, inp_count, inp_data, n_xfer, n_xfer + 100);
                end
                if (n_xfer > 0) begin
                    total++;
                    if (t - last_t !== 3) begin
                        bad++;
                        $display("FAIL period_%0d: got %0d cycles required 3", n_xfer, t - last_t);
                    end
                end
                last_t = t;
                n_xfer++;
            end
            step();
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL frame_timeout: got busy=%b required 0 within bound", busy);
        end
        total++;
        if (n_xfer !== 784) begin
            bad++;
            $display("FAIL xfer_total: got %0d required 784", n_xfer);
        end
        total++;
        if (n_done !== 1) begin
            bad++;
            $display("FAIL done_pulses: got %0d required 1", n_done);
        end
        total++;
        if (inp_count !== 10'd783) begin
            bad++;
            $display("FAIL count_after_done: got %0d required 783", inp_count);
        end
        total++;
        if (addr_bad !== 0) begin
            bad++;
            $display("FAIL addr_tracks_count: got %0d differing cycles required 0", addr_bad);
        end
    endtask

    task automatic test_stall();
        start_and_run_to(10);
        inp_ack = 1'b0;
        step(); step();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (inp_rdy !== 1'b1 || inp_data !== 16'd110 || inp_count !== 10'd10 || mem_rd_en !== 1'b0) begin
                bad++;
                $display("FAIL stall_%0d: got rdy=%b data=%0d count=%0d rd=%b required 1/110/10/0",
                         i, inp_rdy, inp_data, inp_count, mem_rd_en);
            end
            step();
        end
        inp_ack = 1'b1;
        step();
        total++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 10'd11) begin
            bad++;
            $display("FAIL stall_release: got rd=%b addr=%0d required 1/11", mem_rd_en, mem_addr);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_abort();
        start_and_run_to(400);
        step(); step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || inp_rdy !== 1'b0 || done !== 1'b0 || inp_count !== 10'd400) begin
            bad++;
            $display("FAIL abort_idle: got busy=%b rdy=%b done=%b count=%0d required 0/0/0/400",
                     busy, inp_rdy, done, inp_count);
        end
        step();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_done: got done=%b busy=%b required 0/0", done, busy);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (mem_rd_en !== 1'b1 || inp_count !== 10'd0 || mem_addr !== 10'd0) begin
            bad++;
            $display("FAIL restart: got rd=%b count=%0d addr=%0d required 1/0/0", mem_rd_en, inp_count, mem_addr);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_start_ignored();
        start_and_run_to(50);
        start = 1'b1;
        step(); step();
        total++;
        if (inp_rdy !== 1'b1 || inp_count !== 10'd50 || inp_data !== 16'd150) begin
            bad++;
            $display("FAIL busy_start_send: got rdy=%b count=%0d data=%0d required 1/50/150",
                     inp_rdy, inp_count, inp_data);
        end
        step();
        start = 1'b0;
        total++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 10'd51) begin
            bad++;
            $display("FAIL busy_start_next: got rd=%b addr=%0d required 1/51", mem_rd_en, mem_addr);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || inp_count !== 10'd51) begin
            bad++;
            $display("FAIL abort_hold: got busy=%b count=%0d required 0/51", busy, inp_count);
        end
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || mem_rd_en !== 1'b0 || inp_count !== 10'd51) begin
            bad++;
            $display("FAIL abort_start_idle: got busy=%b rd=%b count=%0d required 0/0/51",
                     busy, mem_rd_en, inp_count);
        end
    endtask

    task automatic test_reset_midframe();
        start_and_run_to(200);
        step(); step();
        reset = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        step();
        total++;
        if ({inp_rdy, mem_rd_en, busy, done} !== 4'b0000 || inp_count !== 10'd0 || inp_data !== 16'd0) begin
            bad++;
            $display("FAIL reset_midframe: got rdy/rd/busy/done=%b count=%0d data=%0d required 0000/0/0",
                     {inp_rdy, mem_rd_en, busy, done}, inp_count, inp_data);
        end
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        step();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle: got busy=%b required 0", busy);
        end
    endtask

`ifdef MNIST_STREAMER_FRAME_CNT_EN
    task automatic test_frame_cnt();
        total++;
        if (frame_cnt !== 16'd0) begin
            bad++;
            $display("FAIL frame_cnt_reset: got %0d required 0", frame_cnt);
        end
        for (int f = 0; f < 2; f++) begin
            inp_ack = 1'b1;
            start = 1'b1;
            step();
            start = 1'b0;
            for (int n = 0; n < 3000 && busy; n++) step();
        end
        total++;
        if (frame_cnt !== 16'd2) begin
            bad++;
            $display("FAIL frame_cnt_two: got %0d required 2", frame_cnt);
        end
    endtask
`endif

    initial begin
        clk = 1'b0; reset = 1'b1; start = 1'b0; abort = 1'b0; inp_ack = 1'b0;
        total = 0; bad = 0;
        test_reset();
        test_full_frame();
        test_stall();
        test_abort();
        test_start_ignored();
        test_reset_midframe();
`ifdef MNIST_STREAMER_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mnist_input_streamer.md
MNIST_INPUT_STREAMER -- requirements
Module: mnist_input_streamer

Interface
REQ-001 Parameter N_INPUTS, default 784, number of pixels per image frame.
REQ-002 Parameter DATA_W, default 16, pixel word width.
REQ-003 Parameter ADDR_W, default 10, pixel memory address and count width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  begin streaming one frame; sampled only in IDLE.
REQ-007 abort  input  1  terminate the frame in progress and return to IDLE.
REQ-008 mem_rd_en  output  1  pixel memory read strobe.
REQ-009 mem_addr  output  ADDR_W  pixel memory read address.
REQ-010 mem_rd_data  input  DATA_W  pixel memory data, valid the cycle after mem_rd_en.
REQ-011 inp_rdy  output  1  inp_data/inp_count valid toward the network.
REQ-012 inp_ack  input  1  network accepts the current pixel.
REQ-013 inp_data  output  DATA_W  current pixel value.
REQ-014 inp_count  output  ADDR_W  index of the current pixel, 0..N_INPUTS-1.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse after the last pixel is accepted.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, WAIT, SEND, DONE.
REQ-018 IDLE: start=1 -> clear inp_count to 0 and go to FETCH; otherwise stay in IDLE.
REQ-019 FETCH: mem_rd_en=1, mem_addr=inp_count, for exactly one cycle; next state WAIT.
REQ-020 WAIT: capture mem_rd_data into inp_data at the end of the cycle; next state SEND.
REQ-021 SEND: inp_rdy=1; inp_data and inp_count SHALL remain stable until inp_ack=1.
REQ-022 SEND with inp_ack=1 and inp_count<N_INPUTS-1: inp_count increments by 1; next state FETCH.
REQ-023 SEND with inp_ack=1 and inp_count==N_INPUTS-1: inp_count holds; next state DONE.
REQ-024 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-025 Minimum pixel period SHALL be 3 cycles (FETCH, WAIT, SEND with inp_ack already high).
REQ-026 inp_rdy SHALL be 0 outside SEND; inp_ack outside SEND SHALL be ignored.
REQ-027 mem_rd_en SHALL be 0 outside FETCH; mem_addr SHALL equal inp_count in every cycle.
REQ-028 start while busy=1 SHALL be ignored.
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE next cycle with no done pulse; inp_count holds its value.
REQ-030 abort and start asserted together in IDLE: abort wins, state stays IDLE.
REQ-031 inp_count SHALL never exceed N_INPUTS-1; N_INPUTS=1 SHALL be supported (FETCH, WAIT, SEND, DONE).

Reset
REQ-032 reset=1 at a rising edge SHALL force state IDLE, inp_count=0, inp_data=0, inp_rdy=0, mem_rd_en=0, busy=0, done=0.
REQ-033 reset SHALL take priority over start, abort and inp_ack, including mid-frame.

Configuration
REQ-034 Macro MNIST_STREAMER_FRAME_CNT_EN, when defined, SHALL add output frame_cnt (16 bits), reset to 0, incremented in the DONE cycle, wrapping 65535 -> 0, not incremented on abort.
REQ-035 Without MNIST_STREAMER_FRAME_CNT_EN the frame_cnt port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-036 Reset, then start pulse, memory word[i]=i+100, inp_ack held at 1 -> 784 transfers with inp_count 0..783 and inp_data 100..883, one transfer every 3 cycles, done pulses once.
REQ-037 inp_ack held 0 for 5 cycles in SEND at pixel 10 -> inp_rdy stays 1, inp_data=110 and inp_count=10 stable, no mem_rd_en until after the ack.
REQ-038 abort at pixel 400 -> IDLE next cycle, busy=0, no done, inp_count=400; new start restarts at inp_count=0.
REQ-039 start pulsed at pixel 50 and abort+start together in IDLE -> both ignored, frame and state unaffected.
REQ-040 reset asserted at pixel 200 -> all outputs at reset values the next cycle; with MNIST_STREAMER_FRAME_CNT_EN, frame_cnt=0 after reset and 2 after two complete frames.
